// File: rtl/s_mem_pkg.sv
// -----------------------------------------------------------------------------
// s_mem_pkg
// Shared definitions for the S coefficient memory and its arbiter.
// The S memory holds 8 polynomial slots of 11 words each: word 0 of a slot is
// the degree N, words 1..10 are the coefficients.
// -----------------------------------------------------------------------------
package s_mem_pkg;

   localparam int S_SLOT_SIZE = 11;
   localparam int S_NUM_SLOTS = 8;
   localparam int S_DEPTH     = S_SLOT_SIZE * S_NUM_SLOTS;
   localparam int S_ADDR_W    = 8;
   localparam int S_DATA_W    = 16;

   typedef logic [S_ADDR_W-1:0] s_addr_t;
   typedef logic [S_DATA_W-1:0] s_data_t;

   // Which requester owns the memory port in the current cycle.
   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_WR   = 2'd1,
      WIN_RD   = 2'd2
   } win_t;

   // Address of word 0 (the N word) of polynomial slot 'slot'.
   function automatic s_addr_t slot_base(input logic [2:0] slot);
      return S_ADDR_W'(slot * S_SLOT_SIZE);
   endfunction

endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin priority picker. Scans the request vector starting at index
// 'ptr' and moving upward with wrap-around; the first asserted request wins.
//
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  index with highest priority this cycle
//   gnt   out N      one-hot grant (all zero when no request)
//   idx   out IDX_W  index of the granted request (0 when none)
//   found out 1      at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [IDX_W-1:0] cand;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment; a path that leaves a variable unassigned infers a latch.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int off = 0; off < N; off++) begin
         cand = IDX_W'((int'(ptr) + off) % N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/s_mem_arbiter.sv
// -----------------------------------------------------------------------------
// s_mem_arbiter
// Shares the single-port S coefficient memory between one store-polynomial
// writer and NUM_RD polynomial-evaluation readers. One access is granted per
// cycle, combinationally from the current requests; read data returns to the
// granted reader one cycle later with a one-hot valid.
//
// Priority: the writer normally beats the readers, but once some reader has
// lost MAX_WAIT consecutive cycles the readers take the next slot. Among the
// readers the choice is round-robin.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   rst_instr         synchronous active-low soft clear
//   wr_req/addr/data  writer request (held until wr_gnt)
//   wr_gnt            write accepted this cycle
//   rd_req/rd_addr    per-reader requests; reader i address at [8i+7:8i]
//   rd_gnt            one-hot read grant
//   rd_valid, rd_data read return, one cycle after rd_gnt
//   mem_*             memory port (mem_rdata has 1-cycle latency)
//   err_oob           registered pulse: a granted access was out of range
// -----------------------------------------------------------------------------
module s_mem_arbiter #(
   parameter int NUM_RD   = 2,
   parameter int S_DEPTH  = s_mem_pkg::S_DEPTH,
   parameter int MAX_WAIT = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 rst_instr,
   input  logic                                 wr_req,
   input  logic [s_mem_pkg::S_ADDR_W-1:0]        wr_addr,
   input  logic [s_mem_pkg::S_DATA_W-1:0]        wr_data,
   output logic                                 wr_gnt,
   input  logic [NUM_RD-1:0]                    rd_req,
   input  logic [NUM_RD*s_mem_pkg::S_ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]                    rd_gnt,
   output logic [NUM_RD-1:0]                    rd_valid,
   output logic [s_mem_pkg::S_DATA_W-1:0]        rd_data,
   output logic                                 mem_en,
   output logic                                 mem_we,
   output logic [s_mem_pkg::S_ADDR_W-1:0]        mem_addr,
   output logic [s_mem_pkg::S_DATA_W-1:0]        mem_wdata,
   input  logic [s_mem_pkg::S_DATA_W-1:0]        mem_rdata,
   output logic                                 err_oob
);

   import s_mem_pkg::*;

   localparam int RR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam int WC_W = $clog2(MAX_WAIT + 1);
   localparam logic [WC_W-1:0]   WAIT_MAX  = WC_W'(MAX_WAIT);
   localparam logic [S_ADDR_W:0] DEPTH_LIM = (S_ADDR_W + 1)'(S_DEPTH);

   // Registered state
   logic [RR_W-1:0]   rr_ptr;
   logic [WC_W-1:0]   wait_cnt;
   logic [NUM_RD-1:0] rd_valid_q;
   logic              oob_q;

   // Combinational decode
   logic              active;
   s_addr_t           rd_addr_arr [NUM_RD];
   logic [NUM_RD-1:0] pick_gnt;
   logic [RR_W-1:0]   rd_idx;
   logic              any_rd;
   win_t              win;
   s_addr_t           win_addr;
   s_data_t           win_data;
   logic              win_oob;
   logic [WC_W-1:0]   wait_nxt;
   logic [RR_W-1:0]   rr_nxt;

   // Both resets block every grant in the cycle they are low.
   assign active = rst & rst_instr;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_addr
      assign rd_addr_arr[i] = rd_addr[i*S_ADDR_W +: S_ADDR_W];
   end

   rr_pick #(
      .N     (NUM_RD),
      .IDX_W (RR_W)
   ) u_rr_pick (
      .req   (rd_req),
      .ptr   (rr_ptr),
      .gnt   (pick_gnt),
      .idx   (rd_idx),
      .found (any_rd)
   );

   // Winner selection: a starved reader first, then the writer, then readers.
   always_comb begin
      win = WIN_NONE;
      if (active) begin
         if (any_rd && (wait_cnt == WAIT_MAX)) begin
            win = WIN_RD;
         end else if (wr_req) begin
            win = WIN_WR;
         end else if (any_rd) begin
            win = WIN_RD;
         end
      end
   end

   // Address and data of the winning access.
   always_comb begin
      win_addr = '0;
      win_data = '0;
      case (win)
         WIN_WR: begin
            win_addr = wr_addr;
            win_data = wr_data;
         end
         WIN_RD:  win_addr = rd_addr_arr[rd_idx];
         default: ;
      endcase
   end

   // Out-of-range accesses are still granted (the requester is released) but
   // never reach the memory macro.
   assign win_oob = (win != WIN_NONE) && ({1'b0, win_addr} >= DEPTH_LIM);

   assign wr_gnt    = (win == WIN_WR);
   assign rd_gnt    = (win == WIN_RD) ? pick_gnt : '0;
   assign mem_en    = (win != WIN_NONE) && !win_oob;
   assign mem_we    = mem_en && (win == WIN_WR);
   assign mem_addr  = win_addr;
   assign mem_wdata = win_data;

   // Starvation counter: counts cycles where a reader waits without a grant.
   always_comb begin
      wait_nxt = wait_cnt;
      if ((win == WIN_RD) || !any_rd) begin
         wait_nxt = '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_nxt = wait_cnt + 1'b1;
      end
   end

   // Next round-robin start: one past the reader just served, with wrap.
   assign rr_nxt = (rd_idx == RR_W'(NUM_RD - 1)) ? '0 : rd_idx + 1'b1;

   // NOTE: clocked state uses non-blocking assignments so every register samples
   // the pre-edge values; blocking here would make results depend on statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr     <= '0;
         wait_cnt   <= '0;
         rd_valid_q <= '0;
         oob_q      <= 1'b0;
         err_oob    <= 1'b0;
      end else if (!rst_instr) begin
         rr_ptr     <= '0;
         wait_cnt   <= '0;
         rd_valid_q <= '0;
         oob_q      <= 1'b0;
         err_oob    <= 1'b0;
      end else begin
         wait_cnt   <= wait_nxt;
         if (win == WIN_RD) begin
            rr_ptr <= rr_nxt;
         end
         rd_valid_q <= rd_gnt;
         oob_q      <= (win == WIN_RD) && win_oob;
         err_oob    <= win_oob;
      end
   end

   // A read granted just before a soft clear is dropped: the valid is masked in
   // the clear cycle itself, so the requester has to re-request.
   assign rd_valid = rd_valid_q & {NUM_RD{rst_instr}};
   assign rd_data  = ((|rd_valid) && !oob_q) ? mem_rdata : '0;

endmodule

// File: doc/s_mem_arbiter.md
Name: s_mem_arbiter

Overview:
- Shares the single-port coefficient store (S memory: 8 polynomial slots x 11 words; word 0 of each slot is N, words 1..10 are coefficients) between one store-polynomial writer and NUM_RD polynomial-evaluation readers.
- Picks one access per cycle and drives the memory port.
- Returns read data to the granted reader with a tagged valid one cycle later.
- Sits between the STP unit, the EVP FSM instances and the S memory macro.

Parameters:
- NUM_RD, 2, number of reader ports (2..4)
- S_DEPTH, 88, number of valid S words (8 slots x 11)
- MAX_WAIT, 4, cycles a pending reader may lose to the writer before it wins priority

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-low
- rst_instr  in  1  synchronous active-low soft clear
- wr_req  in  1  writer requests one write
- wr_addr  in  8  write address
- wr_data  in  16  write data
- wr_gnt  out  1  write accepted this cycle
- rd_req  in  NUM_RD  per-reader request
- rd_addr  in  NUM_RD*8  flattened read addresses; reader i uses bits [8i+7:8i]
- rd_gnt  out  NUM_RD  one-hot read grant
- rd_valid  out  NUM_RD  one-hot; read data valid for reader i
- rd_data  out  16  shared read data bus
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  8  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, 1-cycle synchronous latency
- err_oob  out  1  registered pulse: a granted access had address >= S_DEPTH

Behaviour:
- Reset (rst low, async): rr_ptr=0, wait_cnt=0, rd_valid=0, oob_q=0, err_oob=0. Combinational outputs are 0 while rst or rst_instr is low: wr_gnt, rd_gnt, mem_en, mem_we.
- rst_instr low: synchronous clear of the same registers; no grants issued that cycle.
- Handshake:
  - A requester holds req/addr (and wr_data) stable until it sees gnt.
  - A gnt pulse consumes exactly one access.
  - req may stay high to request the next access in the following cycle.
  - Grants are combinational from current req and registered state: zero-cycle grant.
- Arbitration, one winner per cycle:
  - If wait_cnt==MAX_WAIT and any rd_req is high, a reader wins.
  - Else if wr_req is high, the writer wins.
  - Else a reader wins if any rd_req is high.
- Reader choice: round-robin, searching from rr_ptr upward with wrap. After a read grant to reader k, rr_ptr <= (k+1) mod NUM_RD. rr_ptr is unchanged on write grants and idle cycles.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, in cycles with some rd_req high and no read grant.
  - Clears on any read grant, or when no rd_req is high.
- Memory drive (combinational from the winner):
  - mem_en=1 for a winner with addr < S_DEPTH.
  - mem_we=1 only for a write.
  - mem_addr/mem_wdata come from the winner.
  - A winner with addr >= S_DEPTH is still granted, with mem_en=0.
- Read return:
  - One cycle after rd_gnt[k], rd_valid[k]=1 for one cycle.
  - rd_data = mem_rdata, or 16'h0000 if that access was out of range (oob_q).
  - rd_data is 0 when no rd_valid is high.
- err_oob: asserted one cycle after any out-of-range grant, read or write.
- Ordering: write and read to the same address in adjacent cycles are serialized. A read granted after a write returns the new data.
- Back-to-back: one access per cycle; full throughput with continuous requests.
- Reset mid-operation: a read granted in the cycle before rst_instr goes low gets no rd_valid. The requester must re-request.

Decomposition:
- Shared package s_mem_pkg holds:
  - S_SLOT_SIZE=11, S_NUM_SLOTS=8, S_DEPTH=88
  - S_ADDR_W=8, S_DATA_W=16
  - slot base helper: A*11
- Sub-module rr_pick: NUM_RD-wide round-robin priority picker. Inputs req vector and pointer; outputs one-hot grant and index.

Test Plan:
- Single reader: rd_req[0] addr 11, mem holds 16'h0003 -> rd_gnt[0] same cycle; next cycle rd_valid[0]=1, rd_data=16'h0003.
- Write then read: wr_req addr 23 data 16'h00A5, and rd_req[1] addr 23 in the same cycle -> cycle0 wr_gnt; cycle1 rd_gnt[1]; cycle2 rd_valid[1], rd_data=16'h00A5.
- Round-robin: rd_req=2'b11 held 4 cycles, no writer -> grant order 0,1,0,1.
- Starvation guard: wr_req held high, rd_req[0] high, MAX_WAIT=4 -> 4 wr_gnt cycles, then rd_gnt[0] in cycle 4, then the writer resumes.
- Out of range: rd_req[1] addr 90 -> rd_gnt[1], mem_en=0; next cycle rd_valid[1]=1, rd_data=0, err_oob=1.
- Soft clear: read granted at cycle n, rst_instr low at n+1 -> no rd_valid at n+1; rr_ptr=0 and wait_cnt=0 afterward. Async rst low mid-burst -> all outputs 0 immediately.
